// File: rtl/move_input_conditioner_if.sv
// Move-event handshake between the input conditioner (master) and the game FSM (slave).
// move_dir is meaningful only while move_valid is high.
interface move_input_conditioner_if;
    logic       move_valid;
    logic       move_ready;
    logic [1:0] move_dir;

    modport master (
        output move_valid,
        output move_dir,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_dir,
        output move_ready
    );
endinterface

// File: rtl/move_input_conditioner.sv
// Conditions four raw direction buttons into single move events: synchronise, debounce,
// arbitrate by priority, and hold one event per press until the game FSM accepts it.
module move_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk_25Mhz,
    input  logic                      reset,
    input  logic                      mov_left,
    input  logic                      mov_right,
    input  logic                      mov_up,
    input  logic                      mov_down,
    output logic [3:0]                btn_state,
    output logic [7:0]                move_count,
    move_input_conditioner_if.master  move_bus
);

    localparam int unsigned NumBtn = 4;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    localparam logic [1:0] DirLeft  = 2'b00;
    localparam logic [1:0] DirRight = 2'b01;
    localparam logic [1:0] DirUp    = 2'b10;
    localparam logic [1:0] DirDown  = 2'b11;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if ((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StLock
    } state_e;

    logic [NumBtn-1:0] raw;
    logic [NumBtn-1:0] pressed_raw;
    logic [NumBtn-1:0] sync1_q;
    logic [NumBtn-1:0] sync2_q;
    logic [NumBtn-1:0] lvl_q;
    logic [NumBtn-1:0] lvl_d;
    logic [CNT_W-1:0]  cnt_q [NumBtn];
    logic [CNT_W-1:0]  cnt_d [NumBtn];

    state_e     state_q;
    state_e     state_d;
    logic [1:0] dir_q;
    logic [1:0] dir_d;
    logic [7:0] count_q;
    logic [7:0] count_d;

    // Internally a 1 always means pressed, whatever the board polarity.
    assign raw         = {mov_down, mov_up, mov_right, mov_left};
    assign pressed_raw = BTN_ACTIVE_LOW ? ~raw : raw;

    // Reset value 0 is the released level, so no spurious press follows reset.
    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pressed_raw;
            sync2_q <= sync1_q;
        end
    end

    // A level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        for (int i = 0; i < NumBtn; i++) begin
            cnt_d[i] = cnt_q[i];
            lvl_d[i] = lvl_q[i];
            if (sync2_q[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                cnt_d[i] = '0;
                lvl_d[i] = ~lvl_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            lvl_q <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            lvl_q <= lvl_d;
            for (int i = 0; i < NumBtn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            dir_q   <= DirLeft;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            count_q <= count_d;
        end
    end

    // LOCK waits for an all-released vector so a held key never repeats.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (|lvl_q) begin
                    state_d = StIssue;
                    if (lvl_q[0]) begin
                        dir_d = DirLeft;
                    end else if (lvl_q[1]) begin
                        dir_d = DirRight;
                    end else if (lvl_q[2]) begin
                        dir_d = DirUp;
                    end else begin
                        dir_d = DirDown;
                    end
                end
            end
            StIssue: begin
                if (move_bus.move_ready) begin
                    state_d = StLock;
                    count_d = count_q + 8'd1;
                end
            end
            StLock: begin
                if (lvl_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign move_bus.move_valid = (state_q == StIssue);
    assign move_bus.move_dir   = dir_q;
    assign btn_state           = lvl_q;
    assign move_count          = count_q;

endmodule

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
- Sits directly upstream of the game FSM, between the four raw directional push-buttons and the FSM's move inputs.
- Synchronizes and debounces each button, then arbitrates simultaneous presses.
- Issues exactly one move event per physical press, held with a valid/ready handshake until the FSM accepts it.
- Re-arms only after all buttons are released, so a held key never auto-repeats.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized samples required to change a debounced level (10 ms at 25 MHz); minimum 2.
- CNT_W, 18: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 1: 1 = raw buttons read 0 when pressed (board KEYs); 0 = active-high.

Ports:
- clk_25Mhz, input, 1: system clock; all state on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- mov_left, input, 1: raw left button, asynchronous.
- mov_right, input, 1: raw right button, asynchronous.
- mov_up, input, 1: raw up button, asynchronous.
- mov_down, input, 1: raw down button, asynchronous.
- move_ready, input, 1: FSM can accept a move this cycle.
- move_valid, output, 1: a move event is pending.
- move_dir, output, 2: pending direction; 00 left, 01 right, 10 up, 11 down; valid only while move_valid=1.
- btn_state, output, 4: debounced pressed levels {down, up, right, left}, for debug LEDs.
- move_count, output, 8: count of accepted moves; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync-free release): all outputs 0, synchronizers hold the released level, all debounce counters 0, state IDLE.
- Polarity: each raw input is inverted when BTN_ACTIVE_LOW=1. Internally, 1 always means pressed.
- Synchronizer: two flops per button. Total input latency is 2 cycles.
- Debounce, per button:
  - Counter cnt, CNT_W bits. If synced sample == debounced level: cnt <= 0.
  - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1 and the sample still differs: the debounced level flips next edge and cnt <= 0.
  - A level therefore changes only after exactly DEBOUNCE_CYCLES consecutive differing samples. Any single matching sample restarts the count.
  - cnt never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- btn_state is the debounced vector, registered, with no additional latency.
- State machine:
  - IDLE: move_valid=0. If any btn_state bit is 1, latch move_dir by fixed priority left > right > up > down, set move_valid=1 next edge, go to ISSUE.
  - ISSUE: move_valid=1 and move_dir held stable regardless of button activity (releasing the button does not cancel). On move_valid && move_ready: move_valid <= 0, move_count++, go to LOCK. With move_ready=0, it waits indefinitely.
  - LOCK: move_valid=0. When btn_state == 0000, go to IDLE. New presses while any button is still held are ignored.
- Latency, raw press edge (clean) to move_valid: 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- move_ready may be held high constantly: move_valid is then high for exactly 1 cycle per press.
- Simultaneous presses in the same debounced cycle produce one event, for the highest-priority button. The other buttons are swallowed until all are released.
- Press of A, then B while A is still held: only A is issued.
- move_ready is ignored outside ISSUE.
- Reset mid-operation (any state, including ISSUE with the handshake pending): the pending event is discarded and move_count returns to 0. After release, a still-held button is seen as a new press once debounced.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1, move_ready=1 unless noted):
- Clean press: mov_up 1->0 at cycle 0, held 20 cycles -> btn_state=0100 from cycle 6, move_valid=1 only at cycle 7 with move_dir=10, move_count=1, no repeat while held.
- Bounce: mov_left toggles 0/1/0/1 at 1-cycle intervals, then stays 0 -> no event until 4 stable synced samples, then exactly one event with move_dir=00; a glitch of 3 or fewer cycles never changes btn_state.
- Simultaneous: mov_right and mov_down asserted in the same cycle -> one event with move_dir=01; no second event until both are released and one is pressed again.
- Backpressure: move_ready=0 during the press, button released after 10 cycles, move_ready=1 at cycle 30 -> move_valid stays 1 with move_dir stable until cycle 30, accepted once, count=1.
- Wrap/repeat: 256 press/release cycles of mov_down -> 256 single-cycle events, move_count ends at 0.
- Reset mid-ISSUE: assert reset while move_valid=1 with move_ready=0 -> move_valid and move_count are 0 immediately (asynchronous); after release with the button still held, one new event after 2+4+1 cycles.
